// File: rtl/vis_frame_accumulator.sv
// Double-banked visibility frame accumulator: sums count_i blocks of NVIS signed
// partial sums into one bank while the other bank drains over AXI4-Stream.
module vis_frame_accumulator #(
  parameter int unsigned NVIS     = 15,
  parameter int unsigned IBITS    = 7,
  parameter int unsigned OBITS    = 32,
  parameter int unsigned NBITS    = 8,
  parameter int unsigned SATURATE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NBITS-1:0] count_i,
  input  logic             valid_i,
  input  logic             first_i,
  input  logic             last_i,
  input  logic [IBITS-1:0] revis_i,
  input  logic [IBITS-1:0] imvis_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             last_o,
  output logic [OBITS-1:0] revis_o,
  output logic [OBITS-1:0] imvis_o,
  output logic             drop_o,
  output logic             resync_o
);

  localparam int unsigned IW = (NVIS > 1) ? $clog2(NVIS) : 1;
  localparam int unsigned PW = $clog2(NVIS + 1);
  localparam int unsigned SW = OBITS + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NVIS - 1);

  typedef enum logic {ST_IDLE, ST_ACCUM} state_t;

  state_t           state, state_n;
  logic [IW-1:0]    idx, idx_n, wr_idx;
  logic [NBITS-1:0] block, block_n, limit, limit_n;
  logic             sel, drain_full, swap_dly;
  logic [PW-1:0]    rd_ptr;
  logic             wr_en, wr_clear, start, frame_done, resync_c;
  logic             last_hs, drain_free, swap_c, drop_c;
  logic [OBITS-1:0] re_wr, im_wr;

  logic [OBITS-1:0] re_mem [2][NVIS];
  logic [OBITS-1:0] im_mem [2][NVIS];

  // Sign-extended add with optional clamp to the OBITS signed range.
  function automatic logic [OBITS-1:0] acc_add(input logic [OBITS-1:0] base,
                                               input logic [IBITS-1:0] x);
    logic signed [SW-1:0] s;
    s = $signed({base[OBITS-1], base}) + $signed(SW'($signed(x)));
    if (SATURATE != 0 && s[OBITS] != s[OBITS-1])
      return s[OBITS] ? {1'b1, {(OBITS-1){1'b0}}} : {1'b0, {(OBITS-1){1'b1}}};
    return s[OBITS-1:0];
  endfunction

  assign last_hs    = valid_o && ready_i && last_o;
  assign drain_free = !drain_full || last_hs;
  assign swap_c     = frame_done && drain_free;
  assign drop_c     = frame_done && !drain_free;
  assign re_wr      = acc_add(wr_clear ? '0 : re_mem[sel][wr_idx], revis_i);
  assign im_wr      = acc_add(wr_clear ? '0 : im_mem[sel][wr_idx], imvis_i);

  // Input framing FSM; a framing error with first_i restarts on the same beat.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    block_n    = block;
    limit_n    = limit;
    wr_en      = 1'b0;
    wr_idx     = idx;
    wr_clear   = (block == '0);
    start      = 1'b0;
    frame_done = 1'b0;
    resync_c   = 1'b0;
    if (valid_i) begin
      if (state == ST_IDLE) begin
        start = first_i;
      end else if ((first_i && idx != '0) || (last_i && idx != LAST_IDX) ||
                   (!last_i && idx == LAST_IDX)) begin
        resync_c = 1'b1;
        state_n  = ST_IDLE;
        start    = first_i;
      end else begin
        wr_en = 1'b1;
        if (last_i) begin
          idx_n = '0;
          if ((block + NBITS'(1)) == limit) begin
            frame_done = 1'b1;
            state_n    = ST_IDLE;
          end else begin
            block_n = block + NBITS'(1);
          end
        end else begin
          idx_n = idx + IW'(1);
        end
      end
      if (start) begin
        limit_n  = (count_i == '0) ? NBITS'(1) : count_i;
        block_n  = '0;
        idx_n    = IW'(1);
        wr_en    = 1'b1;
        wr_idx   = '0;
        wr_clear = 1'b1;
        state_n  = ST_ACCUM;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      re_mem[sel][wr_idx] <= re_wr;
      im_mem[sel][wr_idx] <= im_wr;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      block      <= '0;
      limit      <= '0;
      sel        <= 1'b0;
      drain_full <= 1'b0;
      swap_dly   <= 1'b0;
      rd_ptr     <= '0;
      valid_o    <= 1'b0;
      last_o     <= 1'b0;
      revis_o    <= '0;
      imvis_o    <= '0;
      drop_o     <= 1'b0;
      resync_o   <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      block    <= block_n;
      limit    <= limit_n;
      drop_o   <= drop_c;
      resync_o <= resync_c;
      swap_dly <= swap_c;
      // swap_dly holds off the first read one cycle after the bank swap
      if (!valid_o || ready_i) begin
        if (drain_full && !swap_dly && rd_ptr < PW'(NVIS)) begin
          valid_o <= 1'b1;
          last_o  <= (rd_ptr == PW'(NVIS - 1));
          revis_o <= re_mem[~sel][IW'(rd_ptr)];
          imvis_o <= im_mem[~sel][IW'(rd_ptr)];
          rd_ptr  <= rd_ptr + PW'(1);
        end else begin
          valid_o <= 1'b0;
          last_o  <= 1'b0;
        end
      end
      if (swap_c) begin
        sel        <= ~sel;
        drain_full <= 1'b1;
        rd_ptr     <= '0;
      end else if (last_hs) begin
        drain_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vis_frame_accumulator.sv
// Directed scoreboard bench for vis_frame_accumulator: default build plus two
// 8-bit output builds (saturating and wrapping) fed from the same input stream.
module tb_vis_frame_accumulator;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  count_i = 8'd1;
  logic        valid_i = 1'b0, first_i = 1'b0, last_i = 1'b0;
  logic [6:0]  revis_i = '0, imvis_i = '0;
  logic        ready_i = 1'b1;

  logic        valid_o, last_o, drop_o, resync_o;
  logic [31:0] revis_o, imvis_o;
  logic        s_valid, s_last, s_drop, s_resync;
  logic [7:0]  s_re, s_im;
  logic        w_valid, w_last, w_drop, w_resync;
  logic [7:0]  w_re, w_im;

  int errors = 0, checks = 0, drop_cnt = 0, resync_cnt = 0;
  int drop_base, resync_base;
  bit toggle_en = 1'b0, sat_phase = 1'b0, found;
  logic [64:0] q[$];
  logic [16:0] sq[$], wq[$];
  logic [64:0] me;
  logic [16:0] se, we;

  vis_frame_accumulator dut (
    .clock(clock), .reset(reset), .count_i(count_i), .valid_i(valid_i),
    .first_i(first_i), .last_i(last_i), .revis_i(revis_i), .imvis_i(imvis_i),
    .valid_o(valid_o), .ready_i(ready_i), .last_o(last_o), .revis_o(revis_o),
    .imvis_o(imvis_o), .drop_o(drop_o), .resync_o(resync_o));

  vis_frame_accumulator #(.OBITS(8), .SATURATE(1)) dut_sat (
    .clock(clock), .reset(reset), .count_i(count_i), .valid_i(valid_i),
    .first_i(first_i), .last_i(last_i), .revis_i(revis_i), .imvis_i(imvis_i),
    .valid_o(s_valid), .ready_i(1'b1), .last_o(s_last), .revis_o(s_re),
    .imvis_o(s_im), .drop_o(s_drop), .resync_o(s_resync));

  vis_frame_accumulator #(.OBITS(8), .SATURATE(0)) dut_wrap (
    .clock(clock), .reset(reset), .count_i(count_i), .valid_i(valid_i),
    .first_i(first_i), .last_i(last_i), .revis_i(revis_i), .imvis_i(imvis_i),
    .valid_o(w_valid), .ready_i(1'b1), .last_o(w_last), .revis_o(w_re),
    .imvis_o(w_im), .drop_o(w_drop), .resync_o(w_resync));

  always #5 clock = ~clock;

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: observed no finish, required finish before timeout");
    $fatal(1, "watchdog");
  end

  // Output monitors pop the scoreboards on each handshake.
  always @(negedge clock) begin
    if (!reset) begin
      if (drop_o) drop_cnt++;
      if (resync_o) resync_cnt++;
      if (valid_o && ready_i) begin
        me = 'x;
        if (q.size() > 0) me = q.pop_front();
        checks++;
        assert ({last_o, revis_o, imvis_o} === me) else begin
          errors++;
          $error("FAIL main_beat: observed %h required %h", {last_o, revis_o, imvis_o}, me);
        end
      end
      if (sat_phase && s_valid) begin
        se = 'x;
        if (sq.size() > 0) se = sq.pop_front();
        checks++;
        assert ({s_last, s_re, s_im, s_drop, s_resync} === {se, 2'b00}) else begin
          errors++;
          $error("FAIL sat_beat: observed %h required %h",
                 {s_last, s_re, s_im, s_drop, s_resync}, {se, 2'b00});
        end
      end
      if (sat_phase && w_valid) begin
        we = 'x;
        if (wq.size() > 0) we = wq.pop_front();
        checks++;
        assert ({w_last, w_re, w_im, w_drop, w_resync} === {we, 2'b00}) else begin
          errors++;
          $error("FAIL wrap_beat: observed %h required %h",
                 {w_last, w_re, w_im, w_drop, w_resync}, {we, 2'b00});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    if (toggle_en) ready_i = ~ready_i;
  endtask

  task automatic beat(input bit f, input bit l, input int re, input int im);
    valid_i = 1'b1; first_i = f; last_i = l;
    revis_i = 7'(re); imvis_i = 7'(im);
    tick();
    valid_i = 1'b0; first_i = 1'b0; last_i = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int re, input int im, input bit l);
    q.push_back({l, 32'(re), 32'(im)});
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 400 && q.size() != 0; k++) tick();
    repeat (3) tick();
    chk(tag, 32'(q.size()), 32'd0);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_valid", 32'(valid_o), 32'd0);
    reset = 1'b0;
    tick();
    chk("rst_out", {valid_o, last_o, drop_o, resync_o, revis_o[13:0], imvis_o[13:0]}, 32'd0);

    // Saturation vs wrap: 200 blocks of +63 / -64.
    sat_phase = 1'b1;
    count_i = 8'd200;
    for (int j = 0; j < 15; j++) begin
      push(12600, -12800, j == 14);
      sq.push_back({j == 14, 8'd127, 8'h80});
      wq.push_back({j == 14, 8'd56, 8'd0});
    end
    for (int b = 0; b < 200; b++)
      for (int i = 0; i < 15; i++) beat(i == 0, i == 14, 63, -64);
    wait_drain("sat_main_drain");
    chk("sat_q_empty", 32'(sq.size()), 32'd0);
    chk("wrap_q_empty", 32'(wq.size()), 32'd0);
    sat_phase = 1'b0;

    // Three-block frame with output latency check.
    count_i = 8'd3;
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < 15; i++) begin
        if (b == 2 && i == 14)
          for (int j = 0; j < 15; j++) push(3 * j, -3 * j, j == 14);
        beat(i == 0, i == 14, i, -i);
      end
    chk("lat_e0", 32'(valid_o), 32'd0);
    tick();
    chk("lat_e1", 32'(valid_o), 32'd0);
    tick();
    chk("lat_e2", 32'(valid_o), 32'd1);
    wait_drain("t1_drain");

    // Back-pressure across two frames: second frame is dropped.
    ready_i = 1'b0;
    count_i = 8'd1;
    drop_base = drop_cnt;
    for (int j = 0; j < 15; j++) push(10 + j, j - 20, j == 14);
    for (int i = 0; i < 15; i++) beat(i == 0, i == 14, 10 + i, i - 20);
    repeat (3) tick();
    chk("hold_valid", 32'(valid_o), 32'd1);
    chk("hold_re", revis_o, 32'd10);
    chk("hold_last", 32'(last_o), 32'd0);
    for (int i = 0; i < 15; i++) beat(i == 0, i == 14, 50, -50);
    chk("drop_pulse", 32'(drop_o), 32'd1);
    tick();
    chk("drop_clear", 32'(drop_o), 32'd0);
    chk("hold_im", imvis_o, 32'(-20));
    ready_i = 1'b1;
    wait_drain("t3_drain");
    chk("drop_count", 32'(drop_cnt - drop_base), 32'd1);

    // Toggling ready; next frame completes on the last_o handshake.
    toggle_en = 1'b1;
    drop_base = drop_cnt;
    count_i = 8'd2;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 15; i++) begin
        if (b == 1 && i == 14)
          for (int j = 0; j < 15; j++) push(2 * j, 4 * j, j == 14);
        beat(i == 0, i == 14, i, 2 * i);
      end
    count_i = 8'd1;
    for (int i = 0; i < 14; i++) beat(i == 0, 1'b0, 7, -7);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      tick();
      found = valid_o && last_o && ready_i;
    end
    chk("align_last_hs", 32'(found), 32'd1);
    for (int j = 0; j < 15; j++) push(7, -7, j == 14);
    beat(1'b0, 1'b1, 7, -7);
    wait_drain("t4_drain");
    chk("t4_no_drop", 32'(drop_cnt - drop_base), 32'd0);
    toggle_en = 1'b0;
    ready_i = 1'b1;

    // Mid-block first_i resynchronises onto a fresh frame.
    count_i = 8'd2;
    resync_base = resync_cnt;
    for (int i = 0; i < 6; i++) beat(i == 0, 1'b0, 20, 20);
    beat(1'b1, 1'b0, 3, -7);
    chk("resync_pulse", 32'(resync_o), 32'd1);
    for (int i = 1; i < 15; i++) beat(1'b0, i == 14, 3, i - 7);
    for (int j = 0; j < 15; j++) push(6, 2 * (j - 7), j == 14);
    for (int i = 0; i < 15; i++) beat(i == 0, i == 14, 3, i - 7);
    wait_drain("t5_drain");
    chk("resync_count", 32'(resync_cnt - resync_base), 32'd1);

    // Reset during drain beat 7 discards everything.
    count_i = 8'd1;
    for (int j = 0; j < 15; j++) push(4 * j, -j, j == 14);
    for (int i = 0; i < 15; i++) beat(i == 0, i == 14, 4 * i, -i);
    for (int k = 0; k < 60 && !(valid_o && revis_o == 32'd28); k++) tick();
    chk("t6_at_beat7", revis_o, 32'd28);
    reset = 1'b1;
    #1;
    chk("t6_async_valid", 32'(valid_o), 32'd0);
    chk("t6_async_re", revis_o, 32'd0);
    q.delete();
    repeat (2) tick();
    reset = 1'b0;
    repeat (40) tick();
    chk("t6_quiet", 32'(valid_o), 32'd0);
    for (int j = 0; j < 15; j++) push(-5, 5, j == 14);
    for (int i = 0; i < 15; i++) beat(i == 0, i == 14, -5, 5);
    wait_drain("t6_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vis_frame_accumulator.md
Name: vis_frame_accumulator

Overview:
- Parametrised successor to the fixed single-accumulator stage behind the correlator/visaccum chain.
- Accumulates blocks of NVIS signed partial-sum visibilities over a runtime-programmable number of blocks.
- Double-banks the results so a finished frame drains over an AXI4-Stream while the next frame accumulates.
- Adds selectable saturation, input-framing resync, and dropped-frame reporting; the output feeds the async FIFO toward the bus clock domain.

Parameters:
- NVIS, 15: visibilities per block (beats per input block), >=2.
- IBITS, 7: signed width of input partial sums.
- OBITS, 32: signed width of accumulated visibilities.
- NBITS, 8: width of count_i.
- SATURATE, 1: 1 = clamp on overflow, 0 = two's-complement wrap.

Ports:
- clock  in  1  correlator clock.
- reset  in  1  asynchronous, active-high reset.
- count_i  in  NBITS  blocks per frame; sampled at frame start; 0 treated as 1.
- valid_i  in  1  input beat valid; no backpressure, always accepted.
- first_i  in  1  beat is index 0 of a block.
- last_i  in  1  beat is index NVIS-1 of a block.
- revis_i  in  IBITS  signed real partial sum.
- imvis_i  in  IBITS  signed imaginary partial sum.
- valid_o  out  1  AXI-S tvalid.
- ready_i  in  1  AXI-S tready.
- last_o  out  1  AXI-S tlast, on beat NVIS-1 of each frame.
- revis_o  out  OBITS  accumulated real part.
- imvis_o  out  OBITS  accumulated imaginary part.
- drop_o  out  1  one-cycle pulse when a completed frame is discarded.
- resync_o  out  1  one-cycle pulse on an input framing error.

Behaviour:
- Reset, asynchronous: valid_o, last_o, drop_o, resync_o, revis_o and imvis_o go to 0. Bank select goes to 0. Both banks are marked empty. Input state is ST_IDLE. Block counter and index counter go to 0.
- Storage: two banks of NVIS x 2*OBITS (RAM or registers). The accumulating bank is acc_bank and the other is drain_bank.
- Input FSM states: ST_IDLE, ST_ACCUM.
  - ST_IDLE: wait for valid_i && first_i. On that beat, latch limit = max(count_i,1), set block = 0 and idx = 0, then go to ST_ACCUM, processing the beat.
  - Beats with valid_i && !first_i in ST_IDLE are ignored silently.
- Accumulate, per accepted beat at idx:
  - block == 0: store sign_extend(input), overwriting any stale data.
  - block > 0: store stored + sign_extend(input).
  - SATURATE=1: the result clamps to [-2^(OBITS-1), 2^(OBITS-1)-1]. SATURATE=0: the result wraps.
  - Read-modify-write completes in one cycle per beat. Back-to-back beats to distinct indices are legal; beats always have distinct indices within a block.
- Framing:
  - idx increments on each beat.
  - A beat with last_i must have idx == NVIS-1.
  - Framing error: first_i at idx != 0, or last_i at idx != NVIS-1, or idx wrapping past NVIS-1 without last_i.
  - On a framing error: pulse resync_o and abandon the frame (acc bank contents are undefined but overwritten later because block restarts at 0). Go to ST_IDLE. If the erroring beat has first_i, it is reprocessed as a new frame start in the same cycle.
- Block end (valid last_i, idx == NVIS-1): block increments. When block+1 == limit, the frame is complete:
  - Drain bank empty: swap banks on the next clock edge, mark the new drain bank full, go to ST_IDLE.
  - Drain bank still draining: discard the frame, pulse drop_o, go to ST_IDLE. The bank is not swapped.
- Output drain:
  - Once drain_bank is full, beats idx 0..NVIS-1 are presented in order.
  - The first valid_o rises 2 cycles after the clock edge accepting the completing last_i (1 cycle swap, 1 cycle registered read).
  - valid_o, revis_o, imvis_o and last_o are registered and hold stable while valid_o && !ready_i.
  - Each handshake (valid_o && ready_i) advances to the next beat with no bubble while ready_i stays high.
  - last_o = 1 only on beat NVIS-1. Its handshake marks drain_bank empty in that same cycle, so a frame completing in that same cycle swaps rather than drops.
- Simultaneous events: accumulation into acc_bank and reads from drain_bank never conflict, because they use separate banks.
- count_i changes mid-frame have no effect until the next frame start.
- Reset mid-drain or mid-accumulate discards all data; no partial frame is emitted after reset deasserts.

Test Plan:
- count_i=3, NVIS=15, inputs revis=idx, imvis=-idx, ready_i=1 -> one 15-beat frame: revis_o=3*idx, imvis_o=-3*idx, last_o on beat 14, first valid_o 2 cycles after the third last_i.
- SATURATE=1, OBITS=8, count_i=200, revis=+63 every beat -> revis_o=127 on all beats. With SATURATE=0 -> revis_o=(200*63) mod 256 interpreted signed = 56.
- ready_i held 0 across two complete frames (count_i=1) -> first frame held stable, drop_o pulses once at the second frame's last_i. Releasing ready_i drains only the first frame's values.
- ready_i toggling 1/0 every cycle -> all 15 beats are delivered in order with no duplication or loss. A third frame completing on the cycle of the last_o handshake is swapped in, not dropped.
- first_i asserted at idx=6 mid-block -> resync_o pulse; the new frame starts from that beat and its output equals a clean count_i-block sum.
- Reset asserted during drain beat 7 -> valid_o=0 immediately (asynchronous); after release, no output until a full new frame completes.
